irq_pending_ctrl: RTL and testbench



---
 rtl/irq_pending_ctrl_pkg.sv | 10 +
 rtl/irq_pending_ctrl_if.sv | 25 ++
 rtl/irq_prio_sel.sv | 20 ++
 rtl/irq_pending_ctrl.sv | 82 ++++++++
 tb/tb_irq_pending_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants and FSM state encoding for the interrupt pending controller.
package irq_pkg;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;
endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Request/mask/ack bundle for irq_pending_ctrl; slave is the controller side.
interface irq_pending_ctrl_if;
  import irq_pkg::*;

  logic [N-1:0]   req;
  logic           mask_we;
  logic [N-1:0]   mask_in;
  logic           ovr_clr;
  logic           irq_ack;
  logic           irq_valid;
  logic [IDW-1:0] irq_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   mask;
  logic [N-1:0]   overrun;

  modport master (
    output req, mask_we, mask_in, ovr_clr, irq_ack,
    input  irq_valid, irq_id, pending, mask, overrun
  );

  modport slave (
    input  req, mask_we, mask_in, ovr_clr, irq_ack,
    output irq_valid, irq_id, pending, mask, overrun
  );
endinterface

// File: rtl/irq_prio_sel.sv
// Combinational N-to-IDW priority selector: highest set index wins, o_any flags any set.
module irq_prio_sel
  import irq_pkg::*;
(
  input  logic [N-1:0]   i_vec,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    // Ascending scan so later (higher) set bits overwrite lower ones.
    for (int unsigned i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_idx = IDW'(i);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/irq_pending_ctrl.sv
// Edge-captured pending interrupts with enable mask, overrun flags and a valid/ack presenter.
module irq_pending_ctrl
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  irq_pending_ctrl_if.slave  bus
);
  logic [N-1:0]   r_req_q, r_pending, r_mask, r_overrun;
  logic           r_valid;
  logic [IDW-1:0] r_id;
  state_e         r_state;

  logic [N-1:0]   w_edge, w_clr, w_eligible;
  logic [IDW-1:0] w_sel, w_id_d;
  logic           w_any, w_accept, w_valid_d;
  state_e         w_state_d;

  assign w_edge     = bus.req & ~r_req_q;
  assign w_accept   = (r_state == ST_PRESENT) && bus.irq_ack;
  assign w_eligible = r_pending & r_mask;

  always_comb begin
    w_clr = '0;
    if (w_accept) w_clr[r_id] = 1'b1;
  end

  irq_prio_sel u_prio_sel (
    .i_vec (w_eligible),
    .o_idx (w_sel),
    .o_any (w_any)
  );

  always_comb begin
    w_state_d = r_state;
    w_valid_d = r_valid;
    w_id_d    = r_id;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_d = ST_PRESENT;
          w_valid_d = 1'b1;
          w_id_d    = w_sel;
        end
      end
      ST_PRESENT: begin
        // Index is frozen here regardless of mask or newer pending lines.
        if (bus.irq_ack) begin
          w_state_d = ST_IDLE;
          w_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_q   <= '0;
      r_pending <= '0;
      r_overrun <= '0;
      r_mask    <= '1;
      r_valid   <= 1'b0;
      r_id      <= '0;
      r_state   <= ST_IDLE;
    end else begin
      r_req_q   <= bus.req;
      // Set beats clear; a fresh overrun beats ovr_clr.
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_overrun <= (bus.ovr_clr ? '0 : r_overrun) | (w_edge & r_pending & ~w_clr);
      if (bus.mask_we) r_mask <= bus.mask_in;
      r_valid   <= w_valid_d;
      r_id      <= w_id_d;
      r_state   <= w_state_d;
    end
  end

  assign bus.irq_valid = r_valid;
  assign bus.irq_id    = r_id;
  assign bus.pending   = r_pending;
  assign bus.mask      = r_mask;
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: directed scenarios plus randomized model comparison.
module tb_irq_pending_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_fail = 0;

  irq_pending_ctrl_if bus ();

  irq_pending_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state, advanced once per clock by tick().
  logic [3:0] m_reqq, m_pend, m_mask, m_ovr;
  logic       m_valid;
  logic [1:0] m_id;

  task automatic tick(input logic r, input logic [3:0] rq, input logic we,
                      input logic [3:0] min, input logic oc, input logic ack);
    logic [3:0] edg, clr, nov, elig;
    int         best;
    rst = r; bus.req = rq; bus.mask_we = we; bus.mask_in = min;
    bus.ovr_clr = oc; bus.irq_ack = ack;
    @(posedge clk);
    if (r) begin
      m_reqq = 0; m_pend = 0; m_ovr = 0; m_mask = 4'hF; m_valid = 0; m_id = 0;
    end else begin
      best = -1;
      for (int i = 0; i < 4; i++) begin
        edg[i] = rq[i] && !m_reqq[i];
        clr[i] = m_valid && ack && (m_id == 2'(i));
        nov[i] = edg[i] && m_pend[i] && !clr[i];
        elig[i] = m_pend[i] && m_mask[i];
        if (elig[i]) best = i;
      end
      if (m_valid) begin
        if (ack) m_valid = 0;
      end else if (best >= 0) begin
        m_valid = 1; m_id = 2'(best);
      end
      m_pend = (m_pend & ~clr) | edg;
      m_ovr  = (oc ? 4'h0 : m_ovr) | nov;
      if (we) m_mask = min;
      m_reqq = rq;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 4'hF, 0, 0, 0, 0);
    tick(1, 4'h0, 0, 0, 0, 0);
    n_vec++;
    if ({bus.irq_valid, bus.irq_id, bus.pending, bus.mask, bus.overrun} !== 15'h00F0) begin
      n_fail++;
      $display("FAIL reset: got v=%b id=%h p=%h m=%h o=%h want v=0 id=0 p=0 m=f o=0",
               bus.irq_valid, bus.irq_id, bus.pending, bus.mask, bus.overrun);
    end
  endtask

  task automatic test_single();
    tick(0, 4'b0100, 0, 0, 0, 1);
    n_vec++;
    if (bus.irq_valid !== 1'b0 || bus.pending !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_pend: got v=%b p=%b want v=0 p=0100", bus.irq_valid, bus.pending);
    end
    tick(0, 4'b0000, 0, 0, 0, 1);
    n_vec++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'b10) begin
      n_fail++;
      $display("FAIL single_grant: got v=%b id=%b want v=1 id=10", bus.irq_valid, bus.irq_id);
    end
    tick(0, 4'b0000, 0, 0, 0, 1);
    n_vec++;
    if (bus.irq_valid !== 1'b0 || bus.pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_ack: got v=%b p=%b want v=0 p=0000", bus.irq_valid, bus.pending);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] want [4] = '{2'b11, 2'b01, 2'b01, 2'b00};
    tick(0, 4'b1011, 0, 0, 0, 0);
    tick(0, 4'b0000, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      n_vec++;
      if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'b11) begin
        n_fail++;
        $display("FAIL simul_hold[%0d]: got v=%b id=%b want v=1 id=11", c, bus.irq_valid,
                 bus.irq_id);
      end
      tick(0, 4'b0000, 0, 0, 0, 0);
    end
    // With ack held: bubble, line 1, bubble, line 0, bubble.
    for (int c = 0; c < 5; c++) begin
      tick(0, 4'b0000, 0, 0, 0, 1);
      n_vec++;
      if (c % 2 == 1) begin
        if (bus.irq_valid !== 1'b1 || bus.irq_id !== want[c]) begin
          n_fail++;
          $display("FAIL simul_seq[%0d]: got v=%b id=%b want v=1 id=%b", c, bus.irq_valid,
                   bus.irq_id, want[c]);
        end
      end else if (bus.irq_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL simul_bubble[%0d]: got v=%b want v=0", c, bus.irq_valid);
      end
    end
    n_vec++;
    if (bus.pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL simul_pend: got %b want 0000", bus.pending);
    end
  endtask

  task automatic test_mask();
    tick(0, 4'b0000, 1, 4'b0111, 0, 1);
    tick(0, 4'b1000, 0, 0, 0, 1);
    for (int c = 0; c < 4; c++) tick(0, 4'b0000, 0, 0, 0, 1);
    n_vec++;
    if (bus.irq_valid !== 1'b0 || bus.pending !== 4'b1000 || bus.mask !== 4'b0111) begin
      n_fail++;
      $display("FAIL mask_block: got v=%b p=%b m=%b want v=0 p=1000 m=0111", bus.irq_valid,
               bus.pending, bus.mask);
    end
    tick(0, 4'b0000, 1, 4'b1111, 0, 0);
    n_vec++;
    if (bus.irq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_wr_edge: got v=%b want v=0", bus.irq_valid);
    end
    tick(0, 4'b0000, 0, 0, 0, 0);
    n_vec++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'b11) begin
      n_fail++;
      $display("FAIL mask_unblock: got v=%b id=%b want v=1 id=11", bus.irq_valid, bus.irq_id);
    end
    tick(0, 4'b0000, 0, 0, 0, 1);
  endtask

  task automatic test_overrun();
    tick(0, 4'b0010, 0, 0, 0, 0);
    tick(0, 4'b0000, 0, 0, 0, 0);
    tick(0, 4'b0010, 0, 0, 0, 0);
    tick(0, 4'b0000, 0, 0, 0, 0);
    n_vec++;
    if (bus.overrun !== 4'b0010) begin
      n_fail++;
      $display("FAIL ovr_set: got %b want 0010", bus.overrun);
    end
    tick(0, 4'b0000, 0, 0, 0, 1);
    for (int c = 0; c < 3; c++) begin
      tick(0, 4'b0000, 0, 0, 0, 1);
      n_vec++;
      if (bus.irq_valid !== 1'b0 || bus.pending !== 4'b0000) begin
        n_fail++;
        $display("FAIL ovr_one_grant[%0d]: got v=%b p=%b want v=0 p=0000", c, bus.irq_valid,
                 bus.pending);
      end
    end
    tick(0, 4'b0000, 0, 0, 1, 0);
    n_vec++;
    if (bus.overrun !== 4'b0000) begin
      n_fail++;
      $display("FAIL ovr_clr: got %b want 0000", bus.overrun);
    end
    tick(0, 4'b0010, 0, 0, 0, 0);
    tick(0, 4'b0000, 0, 0, 0, 0);
    tick(0, 4'b0010, 0, 0, 0, 1);
    n_vec++;
    if (bus.irq_valid !== 1'b0 || bus.pending !== 4'b0010 || bus.overrun !== 4'b0000) begin
      n_fail++;
      $display("FAIL set_beats_clr: got v=%b p=%b o=%b want v=0 p=0010 o=0000",
               bus.irq_valid, bus.pending, bus.overrun);
    end
    tick(0, 4'b0000, 0, 0, 0, 0);
    n_vec++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'b01) begin
      n_fail++;
      $display("FAIL second_grant: got v=%b id=%b want v=1 id=01", bus.irq_valid, bus.irq_id);
    end
    tick(0, 4'b0000, 0, 0, 0, 1);
  endtask

  task automatic test_reset_present();
    tick(0, 4'b0000, 1, 4'b0110, 0, 0);
    tick(0, 4'b0110, 0, 0, 0, 0);
    tick(0, 4'b0000, 0, 0, 0, 0);
    n_vec++;
    if (bus.irq_valid !== 1'b1 || bus.irq_id !== 2'b10 || bus.pending !== 4'b0110) begin
      n_fail++;
      $display("FAIL rstp_pre: got v=%b id=%b p=%b want v=1 id=10 p=0110", bus.irq_valid,
               bus.irq_id, bus.pending);
    end
    tick(1, 4'b0000, 0, 0, 0, 0);
    n_vec++;
    if (bus.irq_valid !== 1'b0 || bus.pending !== 4'b0000 || bus.mask !== 4'b1111 ||
        bus.irq_id !== 2'b00) begin
      n_fail++;
      $display("FAIL rstp_post: got v=%b id=%b p=%b m=%b want v=0 id=00 p=0000 m=1111",
               bus.irq_valid, bus.irq_id, bus.pending, bus.mask);
    end
  endtask

  task automatic test_random();
    logic [14:0] got, exp;
    for (int c = 0; c < 400; c++) begin
      tick(($urandom_range(99) == 0), 4'($urandom), ($urandom_range(15) == 0), 4'($urandom),
           ($urandom_range(9) == 0), ($urandom_range(2) == 0));
      got = {bus.irq_valid, bus.irq_id, bus.pending, bus.mask, bus.overrun};
      exp = {m_valid, m_id, m_pend, m_mask, m_ovr};
      n_vec++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]: got {v,id,p,m,o}=%h want %h", c, got, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.mask_we = 1'b0; bus.mask_in = '0; bus.ovr_clr = 1'b0; bus.irq_ack = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_mask();
    test_overrun();
    test_reset_present();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
